// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory bus of the load/store unit.
// The unit sits on the slave modport; the datapath and memory model sit on the master modport.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Req_Valid;
    logic                  Req_Ready;
    logic                  Req_Write;
    logic [1:0]            Req_Size;
    logic                  Req_Unsigned;
    logic [DATA_WIDTH-1:0] Req_Addr;
    logic [DATA_WIDTH-1:0] Req_WData;
    logic                  Resp_Valid;
    logic [DATA_WIDTH-1:0] Resp_RData;
    logic                  Misaligned;
    logic [DATA_WIDTH-1:0] Mem_Address;
    logic [DATA_WIDTH-1:0] Mem_Write_Data;
    logic                  Mem_MemRead;
    logic                  Mem_MemWrite;
    logic [DATA_WIDTH-1:0] Mem_Read_Data;

    modport slave (
        input  Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Addr, Req_WData, Mem_Read_Data,
        output Req_Ready, Resp_Valid, Resp_RData, Misaligned,
               Mem_Address, Mem_Write_Data, Mem_MemRead, Mem_MemWrite
    );

    modport master (
        output Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Addr, Req_WData, Mem_Read_Data,
        input  Req_Ready, Resp_Valid, Resp_RData, Misaligned,
               Mem_Address, Mem_Write_Data, Mem_MemRead, Mem_MemWrite
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed requests onto a word-addressed data memory,
// with sub-word load extension, read-modify-write sub-word stores and misalignment abort.

// One byte lane of the read-modify-write merge.
module lsu_lane (
    input  logic       sel,
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] merged
);
    assign merged = sel ? new_byte : old_byte;
endmodule

module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic              CLK,
    input  logic              RST,
    load_store_unit_if.slave  bus
);
    localparam int NUM_LANES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic                  write_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wword_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  misaligned_q;

    logic                  accept;
    logic                  mis_in;
    logic [NUM_LANES-1:0]  byte_en;
    logic [DATA_WIDTH-1:0] wrep;
    logic [NUM_LANES-1:0][7:0] merged;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_ext;

    assign accept = (state == IDLE) && bus.Req_Valid;

    always_comb begin
        mis_in = 1'b0;
        case (bus.Req_Size)
            2'b01:   mis_in = bus.Req_Addr[0];
            2'b10:   mis_in = |bus.Req_Addr[1:0];
            2'b11:   mis_in = 1'b1;
            default: mis_in = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.Req_Valid) begin
                    if (mis_in)                  state_nxt = RESP;
                    else if (!bus.Req_Write)     state_nxt = RD;
                    else if (bus.Req_Size == 2'b10) state_nxt = WR;
                    else                         state_nxt = RMW_RD;
                end
            end
            RD:      state_nxt = RESP;
            RMW_RD:  state_nxt = WR;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; decoded from state so the async reset drops the enables at once
    always_comb begin
        bus.Req_Ready    = 1'b0;
        bus.Mem_MemRead  = 1'b0;
        bus.Mem_MemWrite = 1'b0;
        bus.Resp_Valid   = 1'b0;
        case (state)
            IDLE:    bus.Req_Ready    = 1'b1;
            RD:      bus.Mem_MemRead  = 1'b1;
            RMW_RD:  bus.Mem_MemRead  = 1'b1;
            WR:      bus.Mem_MemWrite = 1'b1;
            RESP:    bus.Resp_Valid   = 1'b1;
            default: ;
        endcase
    end

    // Replicating the store data puts it in every lane it could land in.
    always_comb begin
        byte_en = '0;
        wrep    = wdata_q;
        case (size_q)
            2'b00: begin
                byte_en[addr_q[1:0]] = 1'b1;
                wrep = {NUM_LANES{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
                wrep = {(NUM_LANES/2){wdata_q[15:0]}};
            end
            default: byte_en = '1;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lsu_lane u_lane (
            .sel      (byte_en[i]),
            .old_byte (bus.Mem_Read_Data[8*i +: 8]),
            .new_byte (wrep[8*i +: 8]),
            .merged   (merged[i])
        );
    end

    // Halfword addresses here are even, so a byte-granular shift also aligns halves.
    always_comb begin
        shifted  = bus.Mem_Read_Data >> {addr_q[1:0], 3'b000};
        load_ext = bus.Mem_Read_Data;
        case (size_q)
            2'b00:   load_ext = {{(DATA_WIDTH-8){~unsigned_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{(DATA_WIDTH-16){~unsigned_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = bus.Mem_Read_Data;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wword_q      <= '0;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            if (accept) begin
                write_q    <= bus.Req_Write;
                size_q     <= bus.Req_Size;
                unsigned_q <= bus.Req_Unsigned;
                addr_q     <= bus.Req_Addr[ADDR_WIDTH+1:0];
                wdata_q    <= bus.Req_WData;
                if (bus.Req_Write && bus.Req_Size == 2'b10)
                    wword_q <= bus.Req_WData;
            end
            if (state == RMW_RD)
                wword_q <= merged;
            // Response registers only change on entry to RESP so they hold between responses.
            if (state_nxt == RESP) begin
                misaligned_q <= (state == IDLE);
                rdata_q      <= (state == RD && !write_q) ? load_ext : '0;
            end
        end
    end

    assign bus.Resp_RData     = rdata_q;
    assign bus.Misaligned     = misaligned_q;
    assign bus.Mem_Address    = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, addr_q[ADDR_WIDTH+1:2]};
    assign bus.Mem_Write_Data = wword_q;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory interface: accepts load/store requests from the datapath and drives MemRead/MemWrite/Address/Write_Data into the word-addressed data memory.
- Converts byte addresses to word indices and performs byte/halfword extraction with sign or zero extension.
- Implements sub-word stores as read-modify-write and flags misaligned or illegal requests.
- Sits between the execute stage and the data memory; valid/ready handshake on the request side, single-cycle response pulse.

Parameters:
- DATA_WIDTH, 32, data word width; only 32 is supported.
- ADDR_WIDTH, 5, memory word-index width; memory depth is 2**ADDR_WIDTH words.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  unit can accept; high only in IDLE.
- Req_Write  in  1  1 = store, 0 = load.
- Req_Size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- Req_Unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- Req_Addr  in  DATA_WIDTH  byte address.
- Req_WData  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- Resp_Valid  out  1  one-cycle completion pulse.
- Resp_RData  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- Misaligned  out  1  valid with Resp_Valid; request aborted, no memory access.
- Mem_Address  out  DATA_WIDTH  word index {0, addr[ADDR_WIDTH+1:2]}.
- Mem_Write_Data  out  DATA_WIDTH  word to write.
- Mem_MemRead  out  1  memory read enable; memory returns data combinationally.
- Mem_MemWrite  out  1  memory write enable; memory writes at the CLK edge.
- Mem_Read_Data  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset (async, RST=0): state IDLE; Resp_Valid, Misaligned, Mem_MemRead and Mem_MemWrite are 0; Resp_RData, Mem_Address and Mem_Write_Data are 0; request registers cleared. Req_Ready=1 after reset.
- Accept: at a rising edge with Req_Valid=1 in IDLE, latch Write, Size, Unsigned, Addr and WData. Req_Ready is 0 in every other state.
- Check at accept:
  - Misaligned if Size=11, if Size=01 with addr[0]=1, or if Size=10 with addr[1:0]≠0.
- States:
  - IDLE: on accept, if misaligned go to RESP with error set. Otherwise, load goes to RD, word store goes to WR, and byte/half store goes to RMW_RD.
  - RD: Mem_MemRead=1. At the edge, capture Mem_Read_Data, select lane (byte lane=addr[1:0], half lane=addr[1]), extend into Resp_RData, then go to RESP.
  - RMW_RD: Mem_MemRead=1. At the edge, merge the store lane into the captured word (little-endian), then go to WR.
  - WR: Mem_MemWrite=1 and Mem_Write_Data = merged word (or Req_WData for a word store). Go to RESP.
  - RESP: Resp_Valid=1 for exactly one cycle; Misaligned=1 if error. Go to IDLE.
- Mem_MemRead and Mem_MemWrite are never both high. Both are 0 in IDLE and RESP.
- Mem_Address is held stable for the whole access.
- Latency, with accept at edge k:
  - misaligned: Resp_Valid in cycle k+1.
  - load or word store: Resp_Valid in cycle k+2.
  - sub-word store: Resp_Valid in cycle k+3.
  - Max throughput is one request per 3/4 cycles; no pipelining.
- Address bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo 4*2**ADDR_WIDTH bytes.
- Resp_RData and Misaligned hold their values until the next RESP. Resp_Valid is the only qualifier.
- Req_Valid is ignored while not in IDLE. Request inputs may change freely after accept.
- Reset mid-operation: the FSM aborts immediately and enables drop asynchronously. A write occurs only if its WR edge was reached before RST fell; there is no partial RMW write.

Test Plan:
- Word store then load: store addr 0x0000000C, data 0xDEADBEEF; then load word at 0x0C. Expect Mem_Address=3, MemWrite for 1 cycle, then Resp_RData=0xDEADBEEF at k+2.
- Byte loads: memory word 3 = 0x80FF7F01. Load byte 0x0F signed gives 0xFFFFFF80. Load byte 0x0F unsigned gives 0x00000080. Load half 0x0C signed gives 0x00007F01.
- Sub-word store RMW: word 3 = 0x11223344; store byte 0xAA at 0x0D. Expect MemRead cycle, then MemWrite with 0x1122AA44, then Resp_Valid at k+3.
- Misaligned: load word at 0x06. Expect Resp_Valid with Misaligned=1 at k+1, Resp_RData=0, no MemRead/MemWrite. Size=11 behaves the same.
- Reset mid-RMW: assert RST during WR-preceding RMW_RD. Expect all outputs 0 asynchronously, memory word unchanged, Req_Ready=1 after release.
- Wrap and back-pressure: store word at 0x00000080 lands at index 0. Req_Valid held high during a busy load is not accepted until IDLE, and exactly one response is produced per accept.
